mpe_result_packer: RTL and testbench

Downstream stage of the matrix PE. Captures the 32-bit dot-product results, which the PE emits with a valid strobe and no back-pressure, and packs 16 of them into one 512-bit line. Packed lines are buffered in a small line FIFO and written toward NRAM/output SRAM over a valid/ready interface. A flush input drains a partially filled line at the end of an output tile.

---
 rtl/mpe_pkg.sv | 18 +
 rtl/mpe_line_fifo.sv | 61 ++++++
 rtl/mpe_result_packer.sv | 99 +++++++++
 tb/tb_mpe_result_packer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mpe_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mpe_pkg
// Brief  : Shared geometry constants for the matrix-PE result packing path.
// Rev    : 1.0  initial release
// ============================================================================
package mpe_pkg;

    localparam int LANES      = 16;
    localparam int RES_W      = 32;
    localparam int LINE_W     = LANES * RES_W;
    localparam int MASK_W     = LANES;
    localparam int LANE_IDX_W = $clog2(LANES);
    localparam int CNT_W      = LANE_IDX_W + 1;

endpackage : mpe_pkg
`default_nettype wire

// File: rtl/mpe_line_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mpe_line_fifo
// Brief  : Synchronous line FIFO; full/empty told apart by an extra pointer bit.
// Rev    : 1.0  initial release
// ============================================================================
module mpe_line_fifo
    import mpe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = LINE_W + MASK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule : mpe_line_fifo
`default_nettype wire

// File: rtl/mpe_result_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : mpe_result_packer
// Brief  : Packs PE results into 16-lane lines and buffers them for output.
// Rev    : 1.0  initial release
// ============================================================================
module mpe_result_packer
    import mpe_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RES_W-1:0]  pe_result,
    input  logic              pe_vld_o,
    input  logic              flush,
    output logic [LINE_W-1:0] out_data,
    output logic [MASK_W-1:0] out_mask,
    output logic              out_vld,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  lane_cnt,
    output logic              busy,
    output logic              overflow
);

    logic [LINE_W-1:0]     r_pack;
    logic [MASK_W-1:0]     r_mask;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_overflow;

    logic [LINE_W-1:0]     w_pack_next;
    logic [MASK_W-1:0]     w_mask_next;
    logic [LANE_IDX_W-1:0] w_lane_idx;
    logic                  w_last;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

    assign w_lane_idx = r_cnt[LANE_IDX_W-1:0];

    always_comb begin
        w_pack_next = r_pack;
        w_mask_next = r_mask;
        if (pe_vld_o) begin
            w_pack_next[w_lane_idx*RES_W +: RES_W] = pe_result;
            w_mask_next[w_lane_idx]                = 1'b1;
        end
    end

    // A flush landing with the 16th result still yields a single push.
    assign w_last = pe_vld_o && (r_cnt == CNT_W'(LANES - 1));
    assign w_push = w_last || (flush && ((r_cnt != '0) || pe_vld_o));
    assign w_pop  = !w_empty && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack     <= '0;
            r_mask     <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_pack <= '0;
                r_mask <= '0;
                r_cnt  <= '0;
            end else if (pe_vld_o) begin
                r_pack <= w_pack_next;
                r_mask <= w_mask_next;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    mpe_line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LINE_W + MASK_W)
    ) u_line_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({w_mask_next, w_pack_next}),
        .pop       (w_pop),
        .pop_data  ({out_mask, out_data}),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign out_vld  = !w_empty;
    assign lane_cnt = r_cnt;
    assign busy     = (r_cnt != '0) || !w_empty;
    assign overflow = r_overflow;

endmodule : mpe_result_packer
`default_nettype wire

// File: tb/tb_mpe_result_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_mpe_result_packer
// Brief  : Directed stimulus with a line scoreboard for mpe_result_packer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mpe_result_packer;
    import mpe_pkg::*;

    localparam int DW = MASK_W + LINE_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [RES_W-1:0]  pe_result;
    logic              pe_vld_o;
    logic              flush;
    logic [LINE_W-1:0] out_data;
    logic [MASK_W-1:0] out_mask;
    logic              out_vld;
    logic              out_ready;
    logic [CNT_W-1:0]  lane_cnt;
    logic              busy;
    logic              overflow;

    int n_pass  = 0;
    int n_total = 0;
    logic [DW-1:0] exp_q [$];

    mpe_result_packer #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .pe_result (pe_result),
        .pe_vld_o  (pe_vld_o),
        .flush     (flush),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_vld   (out_vld),
        .out_ready (out_ready),
        .lane_cnt  (lane_cnt),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Lines with lane k = base+k for k<n, remaining lanes zero.
    function automatic logic [DW-1:0] mk_line(input int base, input int n);
        logic [LINE_W-1:0] d = '0;
        logic [MASK_W-1:0] m = '0;
        for (int k = 0; k < n; k++) begin
            d[k*RES_W +: RES_W] = RES_W'(base + k);
            m[k]                = 1'b1;
        end
        return {m, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [RES_W-1:0] v, input logic fl);
        pe_vld_o  = 1'b1;
        pe_result = v;
        flush     = fl;
        tick();
        pe_vld_o  = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic feed(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            send(RES_W'(base + k), 1'b0);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_vld && out_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL line: unexpected line mask %h lane0 %h", out_mask, out_data[31:0]);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if ({out_mask, out_data} === e) n_pass++;
                else $display("FAIL line: got mask %h data %h expected mask %h data %h",
                              out_mask, out_data, e[DW-1:LINE_W], e[LINE_W-1:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; out_ready = 1'b1; pe_vld_o = 1'b0; flush = 1'b0; pe_result = '0;
        repeat (3) tick();
        chk("rst_lane_cnt", 32'(lane_cnt), 0);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_out_mask", 32'(out_mask), 0);
        chk("rst_out_data_zero", 32'(out_data == '0), 1);
        rst = 1'b0;
        tick();

        // Full line 0x1..0x10, one-cycle latency, out_vld for one cycle.
        exp_q.push_back(mk_line(1, 16));
        feed(1, 15);
        chk("t1_lane_cnt15", 32'(lane_cnt), 15);
        chk("t1_no_early_vld", 32'(out_vld), 0);
        send(32'h10, 1'b0);
        chk("t1_vld_latency", 32'(out_vld), 1);
        chk("t1_lane_cnt0", 32'(lane_cnt), 0);
        tick();
        chk("t1_vld_one_cycle", 32'(out_vld), 0);

        // Partial flush, then an empty flush that must not emit.
        exp_q.push_back(mk_line('hA0, 5));
        feed('hA0, 5);
        chk("t2_lane_cnt5", 32'(lane_cnt), 5);
        chk("t2_busy", 32'(busy), 1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t2_flush_vld", 32'(out_vld), 1);
        chk("t2_flush_cnt0", 32'(lane_cnt), 0);
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t2_empty_flush_vld", 32'(out_vld), 0);
        chk("t2_empty_flush_busy", 32'(busy), 0);

        // Flush coinciding with the 16th result.
        exp_q.push_back(mk_line('h200, 16));
        feed('h200, 15);
        send(32'h20F, 1'b1);
        chk("t3_lane_cnt0", 32'(lane_cnt), 0);
        chk("t3_vld", 32'(out_vld), 1);
        tick();
        chk("t3_single_push", 32'(out_vld), 0);

        // Back-pressure: 5 lines into a 4-deep FIFO drops the last.
        out_ready = 1'b0;
        for (int l = 0; l < 4; l++) exp_q.push_back(mk_line('h100 + 16*l, 16));
        feed('h100, 64);
        chk("t4_no_ovf_at_full", 32'(overflow), 0);
        feed('h140, 16);
        chk("t4_overflow", 32'(overflow), 1);
        chk("t4_head_lane0", out_data[31:0], 32'h100);
        chk("t4_head_mask", 32'(out_mask), 32'hFFFF);
        repeat (3) tick();
        chk("t4_head_stable", out_data[31:0], 32'h100);
        chk("t4_busy", 32'(busy), 1);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t4_drained", 32'(out_vld), 0);
        chk("t4_ovf_sticky", 32'(overflow), 1);

        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_clears_ovf", 32'(overflow), 0);

        // Push and pop in the same cycle while full: nothing dropped.
        out_ready = 1'b0;
        for (int l = 0; l < 5; l++) exp_q.push_back(mk_line('h300 + 16*l, 16));
        feed('h300, 64);
        feed('h340, 15);
        out_ready = 1'b1;
        send(32'h34F, 1'b0);
        out_ready = 1'b0;
        chk("t5_no_overflow", 32'(overflow), 0);
        chk("t5_new_head", out_data[31:0], 32'h310);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t5_four_held", 32'(out_vld), 1);
        tick();
        chk("t5_drained", 32'(out_vld), 0);

        // Reset mid-operation discards everything held.
        out_ready = 1'b0;
        feed('h400, 32);
        feed('h500, 7);
        chk("t6_pre_cnt", 32'(lane_cnt), 7);
        chk("t6_pre_vld", 32'(out_vld), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_cnt", 32'(lane_cnt), 0);
        chk("t6_rst_vld", 32'(out_vld), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        out_ready = 1'b1;
        exp_q.push_back(mk_line('h600, 16));
        feed('h600, 16);
        repeat (3) tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mpe_result_packer
`default_nettype wire
